switch_input_port: RTL



---
 rtl/io_pkg.sv | 11 +
 rtl/sync_chain.sv | 25 ++
 rtl/switch_input_port.sv | 108 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared types for the pico-MIPS I/O path: push-button debounce FSM states.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } btn_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs; STAGES edges of latency.
module sync_chain #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/switch_input_port.sv
// Input end of the pico-MIPS I/O path: debounced button press latches the switch word
// into a holding register read by the datapath's IN strobe.
module switch_input_port
  import io_pkg::*;
#(
  parameter int N               = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  input  logic         btn,
  input  logic         rd_en,
  output logic [N-1:0] rd_data,
  output logic         valid,
  output logic         overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  sw_s;
  logic          btn_s;
  btn_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          capture, capture_next;

  sync_chain #(.W(N), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk(clk), .reset(reset), .d(sw), .q(sw_s)
  );

  sync_chain #(.W(1), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk(clk), .reset(reset), .d(btn), .q(btn_s)
  );

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    capture_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS;
          cnt_next   = '0;
        end
      end
      PRESS: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next   = HELD;
          capture_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        // A bounce back high during release returns to HELD without a second capture.
        if (btn_s) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      capture <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      capture <= capture_next;
    end
  end

  // Reader handshake: valid marks an unread word; an rd_en edge with valid=1 consumes it.
  // A capture on the same edge as a read wins, so the new word stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (capture) begin
      rd_data <= sw_s;
      valid   <= 1'b1;
      if (valid && !rd_en) overrun <= 1'b1;
      else if (valid && rd_en) overrun <= 1'b0;
    end else if (rd_en && valid) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
